// File: rtl/seq_detect_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared serial 1011 detector and reports per-frame match counts.
// Define SEQ_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module seq_detect_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FRAME_BITS = 8,
    parameter int CNT_W      = 4,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FRAME_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          det_inp_bit,
    output logic                          det_reset,
    input  logic                          det_seq_seen,
    output logic                          done,
    output logic [ID_W-1:0]               done_id,
    output logic [CNT_W-1:0]              match_count
);

    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [BIT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        cnt;
    logic [ID_W-1:0]         cur_id;
    logic [CNT_W-1:0]        res_cnt;
    logic [ID_W-1:0]         res_id;
    logic                    grant_vld;
    logic [ID_W-1:0]         win;
    logic [NUM_REQ-1:0]      gnt_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef SEQ_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the last one written.
    always_comb begin
        grant_vld = 1'b0;
        win       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_vld = 1'b1;
                win       = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] ptr;
    int              idx;

    // Descending scan over offsets from ptr; the smallest offset wins.
    always_comb begin
        grant_vld = 1'b0;
        win       = '0;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                grant_vld = 1'b1;
                win       = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (state == IDLE && grant_vld) begin
            ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        gnt_c     = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt  = CLEAR;
                    gnt_c[win] = 1'b1;
                end
            end
            CLEAR:  state_nxt = SHIFT;
            SHIFT:  if (int'(bit_cnt) == FRAME_BITS - 1) state_nxt = DRAIN;
            DRAIN:  state_nxt = REPORT;
            REPORT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            res_cnt <= '0;
            res_id  <= '0;
        end else begin
            state <= state_nxt;
            // The last seq_seen arrives during DRAIN, so fold it in while capturing the result.
            if (state == DRAIN) begin
                res_cnt <= det_seq_seen ? sat_inc(cnt) : cnt;
                res_id  <= cur_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    shift_reg <= req_data[int'(win)*FRAME_BITS +: FRAME_BITS];
                    cur_id    <= win;
                    cnt       <= '0;
                end
            end
            CLEAR: bit_cnt <= '0;
            SHIFT: begin
                shift_reg <= shift_reg << 1;
                bit_cnt   <= bit_cnt + 1'b1;
                if (det_seq_seen) cnt <= sat_inc(cnt);
            end
            default: ;
        endcase
    end

    // Reset masks every output immediately, even though state clears on the edge.
    assign gnt         = reset ? '0 : gnt_c;
    assign busy        = !reset && (state != IDLE);
    assign det_inp_bit = !reset && (state == SHIFT) && shift_reg[FRAME_BITS-1];
    assign det_reset   = reset || (state == CLEAR);
    assign done        = !reset && (state == REPORT);
    assign done_id     = reset ? '0 : res_id;
    assign match_count = reset ? '0 : res_cnt;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter with a behavioural overlapping 1011 detector attached.
module tb_seq_detect_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        det_inp_bit;
    logic        det_reset;
    logic        det_seq_seen;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  match_count;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  seen_bits;

    seq_detect_arbiter #(
        .NUM_REQ(4), .FRAME_BITS(8), .CNT_W(4), .ID_W(2)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
        .busy(busy), .det_inp_bit(det_inp_bit), .det_reset(det_reset),
        .det_seq_seen(det_seq_seen), .done(done), .done_id(done_id),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    // Overlapping 1011 detector with a registered seq_seen output.
    logic [1:0] dst;
    always @(posedge clk) begin
        if (det_reset) begin
            dst          <= 2'd0;
            det_seq_seen <= 1'b0;
        end else begin
            det_seq_seen <= (dst == 2'd3) && det_inp_bit;
            case (dst)
                2'd0: dst <= det_inp_bit ? 2'd1 : 2'd0;
                2'd1: dst <= det_inp_bit ? 2'd1 : 2'd2;
                2'd2: dst <= det_inp_bit ? 2'd3 : 2'd0;
                default: dst <= det_inp_bit ? 2'd1 : 2'd2;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the grant cycle; returns in the REPORT cycle (or after the bound).
    task automatic wait_done(input int eid, input int ecnt, input bit drop, input string tag);
        int c;
        tick;
        c = 1;
        if (drop) req = '0;
        chk({tag, " clear det_reset"}, det_reset, 1);
        chk({tag, " clear busy"}, busy, 1);
        while (!done && c < 20) begin
            tick;
            c++;
            if (c >= 2 && c <= 9) seen_bits = {seen_bits[6:0], det_inp_bit};
        end
        chk({tag, " latency"}, c, 11);
        chk({tag, " done_id"}, done_id, eid);
        chk({tag, " match_count"}, match_count, ecnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int ecnt [4];
        logic any_done;
        logic [3:0] rq [5];
        logic [3:0] eg [5];
        int eid [5];

        reset = 1'b1; req = '0; req_data = '0; seen_bits = '0;
        tick; tick;
        chk("rst det_reset", det_reset, 1);
        chk("rst busy", busy, 0);
        chk("rst gnt", gnt, 0);
        chk("rst done", done, 0);
        chk("rst det_inp_bit", det_inp_bit, 0);
        chk("rst match_count", match_count, 0);
        chk("rst done_id", done_id, 0);
        reset = 1'b0;
        #1;
        chk("idle det_reset", det_reset, 0);
        chk("idle busy", busy, 0);

        // Single frame, match mid-frame
        req_data[7:0] = 8'hB0; req = 4'b0001;
        #1;
        chk("t1 gnt", gnt, 4'b0001);
        wait_done(0, 1, 1, "t1");
        chk("t1 bit order", seen_bits, 8'hB0);
        tick;
        #1;
        chk("t1 gnt pulse", gnt, 0);
        chk("t1 busy idle", busy, 0);
        chk("t1 done pulse", done, 0);
        chk("t1 count hold", match_count, 1);

        // Match on the last bit, then an empty frame
        req_data[7:0] = 8'hAB; req = 4'b0001;
        #1;
        chk("t2a gnt", gnt, 4'b0001);
        wait_done(0, 1, 1, "t2a");
        tick;
        req_data[7:0] = 8'h00; req = 4'b0001;
        #1;
        chk("t2b gnt", gnt, 4'b0001);
        wait_done(0, 0, 1, "t2b");
        tick;

        req_data = {8'hBB, 8'h00, 8'hAB, 8'hB0};
        ecnt = '{1, 1, 0, 2};
`ifndef SEQ_ARB_FIXED_PRIO_EN
        // Round-robin with all requests held
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req = 4'b1111;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("t3 gnt", gnt, 4'b0001 << (g % 4));
            if (g > 0) chk("t3 spacing", cyc - last, 12);
            last = cyc;
            wait_done(g % 4, ecnt[g % 4], 0, "t3");
            if (g == 4) req = '0;
            tick;
        end

        // Pointer wrap-around and rotation
        rq  = '{4'b0100, 4'b0001, 4'b1010, 4'b1000, 4'b0001};
        eg  = '{4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
        eid = '{2, 0, 1, 3, 0};
        for (int s = 0; s < 5; s++) begin
            req = rq[s];
            #1;
            chk("t4 gnt", gnt, eg[s]);
            wait_done(eid[s], ecnt[eid[s]], 1, "t4");
            tick;
        end
`else
        // Fixed priority: requester 1 always beats requester 2
        req = 4'b0110;
        for (int g = 0; g < 3; g++) begin
            #1;
            chk("t6 gnt", gnt, 4'b0010);
            wait_done(1, 1, 0, "t6");
            if (g == 2) req = '0;
            tick;
        end
`endif

        // Reset during the 4th SHIFT cycle drops the frame
        req_data[23:16] = 8'hB0;
        req = 4'b0100;
        #1;
        chk("t5 gnt", gnt, 4'b0100);
        tick;
        req = '0;
        tick; tick; tick; tick;
        reset = 1'b1;
        #1;
        chk("t5 det_reset", det_reset, 1);
        chk("t5 busy", busy, 0);
        chk("t5 det_inp_bit", det_inp_bit, 0);
        chk("t5 done", done, 0);
        tick;
        reset = 1'b0;
        #1;
        chk("t5 busy after", busy, 0);
        any_done = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick;
            any_done = any_done | done;
        end
        chk("t5 no done", any_done, 0);
        req = 4'b1001;
        #1;
        chk("t5 ptr reset gnt", gnt, 4'b0001);
        wait_done(0, 1, 1, "t5");
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
